// File: rtl/if_id_stage_reg_if.sv
// IF/ID boundary bundle: fetch-side inputs, decode-side registered outputs,
// PC write-enable, FSM status and optional perf counters.
interface if_id_stage_reg_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      pc_plus_two_in;
  logic [15:0]      instr_in;
  logic             instr_valid_in;
  logic             stall_in;
  logic             flush_in;
  logic [15:0]      pc_plus_two_out;
  logic [15:0]      instr_out;
  logic             valid_out;
  logic             pc_en_out;
  logic             halted_out;
  logic             fetch_wait_out;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [CNT_W-1:0] flush_cnt_out;

  modport master (
    output pc_plus_two_in,
    output instr_in,
    output instr_valid_in,
    output stall_in,
    output flush_in,
    input  pc_plus_two_out,
    input  instr_out,
    input  valid_out,
    input  pc_en_out,
    input  halted_out,
    input  fetch_wait_out,
    input  stall_cnt_out,
    input  flush_cnt_out
  );

  modport slave (
    input  pc_plus_two_in,
    input  instr_in,
    input  instr_valid_in,
    input  stall_in,
    input  flush_in,
    output pc_plus_two_out,
    output instr_out,
    output valid_out,
    output pc_en_out,
    output halted_out,
    output fetch_wait_out,
    output stall_cnt_out,
    output flush_cnt_out
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall/flush/bubble/halt control and PC enable.
// Define IFID_PERF_CNT_EN to build saturating stall/flush counters.
module if_id_stage_reg #(
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000,
  parameter int          CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  if_id_stage_reg_if.slave  ifid
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FETCH_WAIT = 2'd1,
    HALTED     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic do_flush;
  logic do_stall;
  logic do_halt;
  logic do_load;
  logic do_bub;
  logic is_halt;

  // Mutually exclusive per-cycle actions in priority order
  assign do_flush = ifid.flush_in;
  assign do_stall = ~ifid.flush_in & ifid.stall_in;
  assign do_halt  = ~ifid.flush_in & ~ifid.stall_in
                  & (state_q == HALTED);
  assign do_load  = ~ifid.flush_in & ~ifid.stall_in
                  & (state_q != HALTED) & ifid.instr_valid_in;
  assign do_bub   = ~ifid.flush_in & ~ifid.stall_in
                  & (state_q != HALTED) & ~ifid.instr_valid_in;
  assign is_halt  = ifid.instr_in[15:11] == HALT_OPCODE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      do_flush: state_d = RUN;
      do_stall: state_d = state_q;
      do_halt:  state_d = HALTED;
      do_load:  state_d = is_halt ? HALTED : RUN;
      do_bub:   state_d = FETCH_WAIT;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    ifid.pc_en_out      = ~rst & (do_flush | do_load);
    ifid.halted_out     = state_q == HALTED;
    ifid.fetch_wait_out = state_q == FETCH_WAIT;
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    unique case (1'b1)
      do_flush: begin
        instr_d = NOP_INSTR;
        pc_d    = 16'h0000;
        valid_d = 1'b0;
      end
      do_stall: begin
        instr_d = instr_q;
      end
      do_halt, do_bub: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      do_load: begin
        instr_d = ifid.instr_in;
        pc_d    = ifid.pc_plus_two_in;
        valid_d = 1'b1;
      end
      default: begin
        instr_d = instr_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign ifid.instr_out       = instr_q;
  assign ifid.pc_plus_two_out = pc_q;
  assign ifid.valid_out       = valid_q;

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturate rather than wrap so long runs stay meaningful
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (do_flush && flush_cnt_q != {CNT_W{1'b1}}) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ifid.stall_cnt_out = stall_cnt_q;
  assign ifid.flush_cnt_out = flush_cnt_q;
`else
  assign ifid.stall_cnt_out = {CNT_W{1'b0}};
  assign ifid.flush_cnt_out = {CNT_W{1'b0}};
`endif

endmodule
